// File: rtl/barrel_normalizer.sv
// barrel_normalizer
//   Shifts a word one bit per clock toward its MSB (direction=1) or its
//   LSB (direction=0) until the first 1 lands in the target end bit. It
//   reports the normalized word and the number of shifts applied. An
//   all-zero word finishes on the accept edge and raises zero.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     upstream word valid
//   in_ready     high only in IDLE while rst is low
//   direction    1 = normalize toward MSB, 0 = toward LSB
//   din          word to normalize (WIDTH bits)
//   out_valid    result valid (DONE state)
//   out_ready    downstream accepts result
//   dout         normalized word
//   shift_value  number of single-bit shifts applied (log2(WIDTH) bits)
//   zero         accepted word was all zeros
module barrel_normalizer #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       direction,
    input  logic [WIDTH-1:0]           din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(WIDTH)-1:0]   shift_value,
    output logic                       zero
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             dir_q, dir_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             target_bit;

    // The bit the leading 1 must reach, chosen by the captured direction
    // so a mid-operation change on the direction port has no effect.
    assign target_bit = dir_q ? work_q[WIDTH-1] : work_q[0];

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = din;
                    dir_d  = direction;
                    cnt_d  = '0;
                    if (din == '0) begin
                        // Nothing to normalize: publish the zero result now.
                        state_d     = DONE;
                        dout_d      = '0;
                        shift_d     = '0;
                        zero_d      = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (target_bit) begin
                    state_d     = DONE;
                    dout_d      = work_q;
                    shift_d     = cnt_q;
                    zero_d      = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    // Word is non-zero, so at most WIDTH-1 shifts happen and
                    // the count cannot wrap.
                    work_d = dir_q ? (work_q << 1) : (work_q >> 1);
                    cnt_d  = cnt_q + SW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Control and published results: cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dout_q      <= '0;
            shift_q     <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Working data: always reloaded on accept, so it needs no reset.
    always_ff @(posedge clk) begin
        work_q <= work_d;
        dir_q  <= dir_d;
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = out_valid_q;
    assign dout        = dout_q;
    assign shift_value = shift_q;
    assign zero        = zero_q;

endmodule

// File: doc/barrel_normalizer.md
BARREL_NORMALIZER -- requirements
Module: barrel_normalizer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width; it is a power of two and at least 4.
REQ-002 The block SHALL derive SW = log2(WIDTH) internally as the shift-count width; SW is not a port parameter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port direction, input, 1 bit: 1 normalizes toward the MSB (left), 0 toward the LSB (right).
REQ-008 The block SHALL have port din, input, WIDTH bits: the word to normalize.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port dout, output, WIDTH bits: the normalized word.
REQ-012 The block SHALL have port shift_value, output, SW bits: the number of single-bit shifts applied.
REQ-013 The block SHALL have port zero, output, 1 bit: the accepted word was all zeros.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE while rst is low; out_valid SHALL be 1 only in DONE.
REQ-016 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; at that edge the block captures din and direction, clears the count, and moves to SHIFT.
REQ-017 An accept of din=0 SHALL instead move directly to DONE with dout=0, shift_value=0 and zero=1.
REQ-018 In SHIFT at each edge, if the target bit of the working register is 1, the block SHALL move to DONE.
- Target bit: bit WIDTH-1 when direction=1, bit 0 when direction=0.
REQ-019 In SHIFT at each edge, if the target bit is 0, the block SHALL shift the working register one bit toward the target, fill with 0 (logical shift, no rotate), increment the count, and stay in SHIFT.
REQ-020 For a non-zero input with k zeros ahead of the first 1 in the shift direction, 0 <= k <= WIDTH-1:
- out_valid SHALL rise at the (k+1)th rising edge after the accept edge;
- shift_value SHALL equal k;
- zero SHALL be 0.
REQ-021 The count SHALL never exceed WIDTH-1 and SHALL never wrap.
REQ-022 Shifting dout by shift_value in the direction opposite to the captured direction, with zero fill, SHALL reproduce the captured din exactly.
REQ-023 In DONE, dout, shift_value and zero SHALL hold stable while out_ready=0.
REQ-024 On an edge in DONE with out_ready=1, the block SHALL return to IDLE.
REQ-025 dout, shift_value and zero SHALL keep their values until the next result is loaded.
REQ-026 A new word SHALL NOT be accepted in the same cycle that a result is delivered; throughput is one word per k+3 cycles minimum.
REQ-027 din, direction and in_valid SHALL be ignored outside IDLE; a change to direction mid-operation SHALL have no effect.
REQ-028 dout, shift_value, zero and out_valid SHALL be driven from registers.

Reset
REQ-029 While rst=1, the block SHALL hold state IDLE, out_valid=0, in_ready=0, dout=0, shift_value=0 and zero=0, independent of clk.
REQ-030 Asserting rst in SHIFT or DONE SHALL abort the operation immediately, with no result delivered.
REQ-031 On the first rising edge after rst deasserts, in_ready SHALL be 1.

Verification
REQ-032 (WIDTH=8) direction=1, din=8'b0001_0110 accepted -> out_valid at the 4th edge after accept, dout=8'b1011_0000, shift_value=3, zero=0.
REQ-033 direction=0, din=8'b0110_1000 -> dout=8'b0000_1101, shift_value=3, out_valid at the 4th edge after accept.
REQ-034 din=8'h00 (either direction) -> out_valid at the accept edge, dout=0, shift_value=0, zero=1.
REQ-035 Boundary cases:
- direction=1, din=8'h01 -> shift_value=7, dout=8'h80;
- direction=1, din=8'h80 -> shift_value=0, out_valid at the 1st edge after accept.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-037 Assert rst two cycles into SHIFT for din=8'h01 -> out_valid never rises, all outputs 0; a new word after reset is processed correctly.
REQ-038 A randomized bench SHALL check REQ-022 and REQ-020 for every accepted word.
